sram_like_bridge: RTL and testbench
===================================

// Module: sram_like_bridge
// PURPOSE
//  Sits directly downstream of mycpu_core's inst_sram_*/data_sram_* ports. Converts the
//  core's fixed-latency SRAM requests into one shared req/addr_ok/data_ok ("sram-like") bus.
//  Drives stallreq_for_bus back into CTRL while any request is outstanding.
//  The core sees ordinary SRAM timing: data arrives in the first cycle stallreq_for_bus is low.
// PARAMETERS
//  DATA_FIRST  1  1: the data channel is served before inst when both are pending; 0: inst first
// PORTS
//  clk               in   1   single clock, rising edge
//  rst               in   1   asynchronous, active-high reset
//  inst_sram_en      in   1   fetch request this cycle
//  inst_sram_wen     in   4   ignored (fetch is always a read)
//  inst_sram_addr    in   32  fetch address
//  inst_sram_wdata   in   32  ignored
//  inst_sram_rdata   out  32  fetched word, held until the next inst completion
//  data_sram_en      in   1   load/store request this cycle
//  data_sram_wen     in   4   byte strobe; 0 = read
//  data_sram_addr    in   32  data address
//  data_sram_wdata   in   32  store data
//  data_sram_rdata   out  32  loaded word, held until the next data read completion
//  stallreq_for_bus  out  1   to CTRL: freeze the pipeline
//  bus_req           out  1   bus request valid
//  bus_wr            out  1   1 = write
//  bus_size          out  2   0 = byte, 1 = half, 2 = word
//  bus_wstrb         out  4   byte strobe (write only)
//  bus_addr          out  32  request address
//  bus_wdata         out  32  write data
//  bus_addr_ok       in   1   request accepted when bus_req & bus_addr_ok
//  bus_data_ok       in   1   read data / write ack valid
//  bus_rdata         in   32  read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending flags cleared.
//  Request latch:
//   - At a rising edge where stallreq_for_bus=0, each channel with en=1 latches addr/wen/wdata into its slot and sets its pend flag.
//   - While stallreq_for_bus=1, en/addr/wdata are ignored; the held core re-presents the same request and must not be duplicated.
//  stallreq_for_bus = ipend | dpend (registered; no combinational path from core inputs).
//  FSM states:
//   - IDLE -> D_REQ if dpend (and DATA_FIRST, or no ipend); else -> I_REQ if ipend.
//   - X_REQ: bus_req=1 with the slot contents. Move to X_WAIT on addr_ok.
//   - X_WAIT: bus_req=0. On data_ok, clear pend and capture bus_rdata into the rdata register (reads only).
//     Then go to the other channel's REQ if it is pending, else IDLE.
//  Size encoding:
//   - inst: size=2, wr=0, wstrb=0.
//   - data: wr=|wen. Size from wen: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; anything else -> 2.
//   - bus_addr = latched address, unchanged.
//  Latency, zero-wait slave (addr_ok same cycle, data_ok next cycle):
//   - single channel: stall lasts 2 cycles;
//   - both channels: stall lasts 4 cycles.
//  Boundaries:
//   - data_ok is sampled only in X_WAIT; a data_ok in IDLE or X_REQ is ignored.
//   - addr_ok is sampled only in X_REQ.
//   - A store completion leaves data_sram_rdata unchanged.
//   - Reset mid-transaction: bus_req drops immediately and all pending work is discarded. The slave shares rst.
// STRUCTURE
//  defines.vh: `BRIDGE_ST_WD and the IDLE/I_REQ/I_WAIT/D_REQ/D_WAIT codes;
//   `BUS_SIZE_B/H/W; the new StallBus bit index for the bus stall.
//  Sub-module sram_req_slot, one instance per channel:
//   - latch enable, pend flag, addr/wen/wdata registers;
//   - clear input driven from the FSM.
//  Top level: FSM, output mux, rdata registers.
// TESTING
//  1. inst_en @0x1000; addr_ok same cycle, data_ok 1 later with 0x2402000A
//     -> stall for 2 cycles, then inst_sram_rdata=0x2402000A with stall=0.
//  2. inst and data read in the same cycle, DATA_FIRST=1
//     -> bus sees data addr first, then inst addr; stall for 4 cycles; both rdata correct.
//  3. store wen=0011 @0x8004, wdata=0xBEEF
//     -> bus_wr=1, size=1, wstrb=0011; data_sram_rdata unchanged after the ack.
//  4. addr_ok held low for 5 cycles
//     -> bus_req and bus_addr stable throughout; stall persists; exactly 1 handshake.
//  5. Core holds en=1 on the same address during the stall
//     -> exactly one bus request issued.
//  6. rst pulse while in D_WAIT
//     -> bus_req=0 and stall=0 asynchronously; a stray data_ok afterwards changes no output.

Source files
------------

// File: rtl/sram_like_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_like_bridge_pkg
// Purpose : Shared types and helpers for the SRAM-to-sram-like bus bridge:
//           FSM state encoding, bus size codes and the write-strobe to
//           transfer-size decoder.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package sram_like_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_REQ  = 3'd1,
    ST_I_WAIT = 3'd2,
    ST_D_REQ  = 3'd3,
    ST_D_WAIT = 3'd4
  } bridge_state_e;

  localparam logic [1:0] BUS_SIZE_B = 2'd0;
  localparam logic [1:0] BUS_SIZE_H = 2'd1;
  localparam logic [1:0] BUS_SIZE_W = 2'd2;

  // Single-byte strobes map to byte, aligned half strobes to half, and
  // everything else (including a read, wen=0) is issued as a full word.
  function automatic logic [1:0] size_from_wen(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = BUS_SIZE_B;
      4'b0011, 4'b1100:                   size = BUS_SIZE_H;
      default:                            size = BUS_SIZE_W;
    endcase
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_bridge_slot.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_bridge_slot
// Purpose : One request slot of the bridge (one per core channel). Captures
//           a core request and keeps it pending until the FSM clears it.
// Ports   : clk, rst      clock, async active-high reset
//           load          capture wen_in/addr_in/wdata_in and set pend
//           clear         drop pend (transaction completed)
//           wen_in/addr_in/wdata_in  request fields from the core
//           pend          request outstanding
//           wen/addr/wdata           latched request fields
// Rev     : 1.0  initial release
// ============================================================================
module sram_like_bridge_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [3:0]  wen_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        pend,
  output logic [3:0]  wen,
  output logic [31:0] addr,
  output logic [31:0] wdata
);

  // load is only ever raised while nothing is pending, and clear only while
  // this slot is pending, so the two never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      wen   <= 4'd0;
      addr  <= 32'd0;
      wdata <= 32'd0;
    end else if (load) begin
      pend  <= 1'b1;
      wen   <= wen_in;
      addr  <= addr_in;
      wdata <= wdata_in;
    end else if (clear) begin
      pend  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module  : sram_like_bridge
// Purpose : Converts the core's fixed-latency inst/data SRAM ports into one
//           shared req/addr_ok/data_ok bus and stalls the pipeline while any
//           request is outstanding. Data reaches the core in the first cycle
//           stallreq_for_bus is low.
// Params  : DATA_FIRST  1: data channel served first when both pending
// Ports   : clk, rst                      clock, async active-high reset
//           inst_sram_*                   fetch port (always a read)
//           data_sram_*                   load/store port (wen=0 is a read)
//           stallreq_for_bus              freeze request to CTRL
//           bus_req/wr/size/wstrb/addr/wdata  bus request channel
//           bus_addr_ok/data_ok/rdata     bus responses
// Rev     : 1.0  initial release
// ============================================================================
module sram_like_bridge
  import sram_like_bridge_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_bus,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  bridge_state_e state_q, state_d;

  logic        ipend, dpend;
  logic        i_load, d_load;
  logic        i_clear, d_clear;
  logic        i_cap, d_cap;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wen;
  logic [3:0]  i_wen_unused;
  logic [31:0] i_wdata_unused;
  logic        unused_inst;

  // A stalled core keeps re-presenting the same request; accept new work
  // only when nothing is outstanding.
  assign stallreq_for_bus = ipend | dpend;
  assign i_load = inst_sram_en & ~stallreq_for_bus;
  assign d_load = data_sram_en & ~stallreq_for_bus;

  sram_like_bridge_slot u_inst_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (i_load),
    .clear    (i_clear),
    .wen_in   (4'd0),
    .addr_in  (inst_sram_addr),
    .wdata_in (32'd0),
    .pend     (ipend),
    .wen      (i_wen_unused),
    .addr     (i_addr),
    .wdata    (i_wdata_unused)
  );

  sram_like_bridge_slot u_data_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (d_load),
    .clear    (d_clear),
    .wen_in   (data_sram_wen),
    .addr_in  (data_sram_addr),
    .wdata_in (data_sram_wdata),
    .pend     (dpend),
    .wen      (d_wen),
    .addr     (d_addr),
    .wdata    (d_wdata)
  );

  // Fetches are always reads; their write fields are intentionally dropped.
  assign unused_inst = ^{inst_sram_wen, inst_sram_wdata, i_wen_unused, i_wdata_unused};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // IDLE looks at the requests being loaded this edge so the bus request is
  // up in the very first stall cycle (2-cycle stall with a zero-wait slave).
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = BUS_SIZE_B;
    bus_wstrb = 4'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    i_clear   = 1'b0;
    d_clear   = 1'b0;
    i_cap     = 1'b0;
    d_cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((dpend | d_load) && (DATA_FIRST || !(ipend | i_load)))
          state_d = ST_D_REQ;
        else if (ipend | i_load)
          state_d = ST_I_REQ;
      end
      ST_I_REQ: begin
        bus_req  = 1'b1;
        bus_size = BUS_SIZE_W;
        bus_addr = i_addr;
        if (bus_addr_ok) state_d = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        if (bus_data_ok) begin
          i_clear = 1'b1;
          i_cap   = 1'b1;
          state_d = dpend ? ST_D_REQ : ST_IDLE;
        end
      end
      ST_D_REQ: begin
        bus_req   = 1'b1;
        bus_wr    = |d_wen;
        bus_size  = size_from_wen(d_wen);
        bus_wstrb = d_wen;
        bus_addr  = d_addr;
        bus_wdata = d_wdata;
        if (bus_addr_ok) state_d = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        if (bus_data_ok) begin
          d_clear = 1'b1;
          d_cap   = ~|d_wen;  // a store ack carries no load data
          state_d = ipend ? ST_I_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rdata <= 32'd0;
      data_sram_rdata <= 32'd0;
    end else begin
      if (i_cap) inst_sram_rdata <= bus_rdata;
      if (d_cap) data_sram_rdata <= bus_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_like_bridge
// Purpose : Directed self-checking bench for sram_like_bridge with a small
//           zero-wait bus slave whose address acceptance can be held off.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_bus;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.DATA_FIRST(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .stallreq_for_bus (stallreq_for_bus),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_size         (bus_size),
    .bus_wstrb        (bus_wstrb),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_addr_ok      (bus_addr_ok),
    .bus_data_ok      (bus_data_ok),
    .bus_rdata        (bus_rdata)
  );

  // ---------------- bus slave model ----------------
  logic        accept_en;
  logic        stray;
  logic        dv;
  logic [31:0] rdata_q;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_wr[$];
  logic [1:0]  log_size[$];
  logic [3:0]  log_wstrb[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'h2402_000A;
      32'h0000_2000: return 32'h1111_2222;
      32'h0000_3000: return 32'h3333_4444;
      default:       return 32'hDEAD_DEAD;
    endcase
  endfunction

  assign bus_addr_ok = bus_req & accept_en;
  assign bus_data_ok = dv | stray;
  assign bus_rdata   = dv ? rdata_q : 32'hBAD0_BAD0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dv      <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      dv <= 1'b0;
      if (bus_req && bus_addr_ok) begin
        dv      <= 1'b1;
        rdata_q <= mem_rd(bus_addr);
        log_addr.push_back(bus_addr);
        log_wdata.push_back(bus_wdata);
        log_wr.push_back(bus_wr);
        log_size.push_back(bus_size);
        log_wstrb.push_back(bus_wstrb);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the first negedge after the request edge; counts stall cycles.
  task automatic count_stall(output int cyc);
    cyc = 0;
    while (stallreq_for_bus && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  int cyc;
  int n0;
  logic ok;
  logic [31:0] d_before;

  initial begin
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    accept_en = 1'b1; stray = 1'b0;
    @(negedge clk); @(negedge clk);
    check_eq("reset_stall", {31'd0, stallreq_for_bus}, 32'd0);
    check_eq("reset_req",   {31'd0, bus_req}, 32'd0);
    check_eq("reset_irdata", inst_sram_rdata, 32'd0);
    check_eq("reset_drdata", data_sram_rdata, 32'd0);
    check_eq("reset_addr",  bus_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single fetch
    n0 = log_addr.size();
    inst_sram_en = 1; inst_sram_addr = 32'h1000;
    @(negedge clk);
    inst_sram_en = 0;
    check_eq("t1_req_first_cycle", {31'd0, bus_req}, 32'd1);
    check_eq("t1_size", {30'd0, bus_size}, 32'd2);
    count_stall(cyc);
    check_eq("t1_stall_cycles", cyc, 32'd2);
    check_eq("t1_irdata", inst_sram_rdata, 32'h2402_000A);
    check_eq("t1_handshakes", log_addr.size() - n0, 32'd1);
    check_eq("t1_addr", log_addr[n0], 32'h1000);

    // 2: simultaneous fetch and load, data first
    @(negedge clk);
    n0 = log_addr.size();
    inst_sram_en = 1; inst_sram_addr = 32'h3000;
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h2000;
    @(negedge clk);
    inst_sram_en = 0; data_sram_en = 0;
    count_stall(cyc);
    check_eq("t2_stall_cycles", cyc, 32'd4);
    check_eq("t2_handshakes", log_addr.size() - n0, 32'd2);
    check_eq("t2_first_addr", log_addr[n0], 32'h2000);
    check_eq("t2_second_addr", log_addr[n0+1], 32'h3000);
    check_eq("t2_first_wr", {31'd0, log_wr[n0]}, 32'd0);
    check_eq("t2_irdata", inst_sram_rdata, 32'h3333_4444);
    check_eq("t2_drdata", data_sram_rdata, 32'h1111_2222);

    // 3: halfword store
    @(negedge clk);
    n0 = log_addr.size();
    data_sram_en = 1; data_sram_wen = 4'b0011; data_sram_addr = 32'h8004;
    data_sram_wdata = 32'h0000_BEEF;
    @(negedge clk);
    data_sram_en = 0;
    count_stall(cyc);
    check_eq("t3_stall_cycles", cyc, 32'd2);
    check_eq("t3_addr", log_addr[n0], 32'h8004);
    check_eq("t3_wr", {31'd0, log_wr[n0]}, 32'd1);
    check_eq("t3_size", {30'd0, log_size[n0]}, 32'd1);
    check_eq("t3_wstrb", {28'd0, log_wstrb[n0]}, 32'h3);
    check_eq("t3_wdata", log_wdata[n0], 32'h0000_BEEF);
    check_eq("t3_drdata_kept", data_sram_rdata, 32'h1111_2222);

    // 4: addr_ok held off 5 cycles, stray data_ok while in request phase
    @(negedge clk);
    n0 = log_addr.size();
    accept_en = 1'b0;
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h2000;
    @(negedge clk);
    data_sram_en = 0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus_req && bus_addr == 32'h2000 && stallreq_for_bus)) ok = 1'b0;
      stray = (i == 2);
      @(negedge clk);
    end
    stray = 1'b0;
    check_eq("t4_held_stable", {31'd0, ok}, 32'd1);
    check_eq("t4_still_stalled", {31'd0, stallreq_for_bus}, 32'd1);
    check_eq("t4_no_handshake_yet", log_addr.size() - n0, 32'd0);
    accept_en = 1'b1;
    count_stall(cyc);
    check_eq("t4_tail_cycles", cyc, 32'd2);
    check_eq("t4_handshakes", log_addr.size() - n0, 32'd1);
    check_eq("t4_drdata", data_sram_rdata, 32'h1111_2222);

    // 5: core holds en during the stall
    @(negedge clk);
    n0 = log_addr.size();
    inst_sram_en = 1; inst_sram_addr = 32'h2000;
    @(negedge clk);
    count_stall(cyc);
    inst_sram_en = 0;
    @(negedge clk); @(negedge clk);
    check_eq("t5_stall_cycles", cyc, 32'd2);
    check_eq("t5_handshakes", log_addr.size() - n0, 32'd1);
    check_eq("t5_irdata", inst_sram_rdata, 32'h1111_2222);
    check_eq("t5_stall_after", {31'd0, stallreq_for_bus}, 32'd0);

    // 6: reset while waiting for load data
    data_sram_en = 1; data_sram_wen = 4'b0000; data_sram_addr = 32'h3000;
    @(negedge clk);
    data_sram_en = 0;
    @(negedge clk);
    check_eq("t6_in_wait_noreq", {31'd0, bus_req}, 32'd0);
    d_before = data_sram_rdata;
    #1 rst = 1'b1;
    #1;
    check_eq("t6_async_req", {31'd0, bus_req}, 32'd0);
    check_eq("t6_async_stall", {31'd0, stallreq_for_bus}, 32'd0);
    check_eq("t6_drdata_not_loaded", (data_sram_rdata == 32'h3333_4444) ? 32'd1 : 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n0 = log_addr.size();
    d_before = data_sram_rdata;
    stray = 1'b1;
    @(negedge clk); @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check_eq("t6_stray_req", {31'd0, bus_req}, 32'd0);
    check_eq("t6_stray_stall", {31'd0, stallreq_for_bus}, 32'd0);
    check_eq("t6_stray_drdata", data_sram_rdata, d_before);
    check_eq("t6_stray_irdata", inst_sram_rdata, 32'd0);
    check_eq("t6_no_handshake", log_addr.size() - n0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
